avalon_seg_display_ctrl: RTL and testbench
==========================================

Name: avalon_seg_display_ctrl

Overview:
Avalon-MM slave that drives NUM_SEGMENT seven-segment digits on DE1-SoC.
- Per-digit controls: hex decode or raw segment pattern, blanking and blinking.
- Global brightness through a PWM dimmer.
- Readback of every control register, with a registered one-cycle read latency.
- Sits between the HPS/Nios lightweight bridge and the HEX0..HEX5 pins.

Parameters:
NUM_SEGMENT, 6, number of digits (1..8).
CLK_FREQ_HZ, 50000000, clk frequency.
BLINK_HZ, 2, blink frequency (full on+off period per second).
PWM_BITS, 4, brightness resolution.
ACTIVE_LOW, 1, 1 = segment lit by 0 (DE1-SoC).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
avms_address_i  in  3  word address
avms_byteenable_i  in  4  write byte lanes
avms_write_i  in  1  write strobe
avms_writedata_i  in  32  write data
avms_read_i  in  1  read strobe
avms_readdata_o  out  32  read data
avms_readdatavalid_o  out  1  read data valid
segment_symbol_o  out  NUM_SEGMENT*7  digit i at [7i+6:7i], bit0=a..bit6=g

Behaviour:
Interface basics
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Register map is word-addressed. Unimplemented bits and bits for digits >= NUM_SEGMENT read 0 and ignore writes.
  0 DIGITS: 4-bit hex code per digit, digit i at [4i+3:4i].
  1 RAW_EN: bit i = digit i shows its RAW pattern instead of the decoded hex.
  2 BLANK: bit i forces digit i off.
  3 BLINK: bit i blanks digit i while blink phase = 1.
  4 BRIGHT: [PWM_BITS-1:0].
  5 RAW_LO: digits 0-3, byte i = pattern [6:0], bit 7 reserved.
  6 RAW_HI: digits 4-7, same layout.
  7 STATUS (RO): bit0 = blink phase; bits[15:8] = NUM_SEGMENT. Writes ignored.

Reset values
- All registers 0 except BRIGHT, which resets to 2^PWM_BITS-1.
- Blink prescaler, phase and PWM counter = 0.
- avms_readdata_o = 0, avms_readdatavalid_o = 0.
- segment_symbol_o = all-off (all 1s when ACTIVE_LOW).

Writes
- A register updates on the clk edge where avms_write_i = 1.
- Byte lane b updates only if avms_byteenable_i[b] = 1.
- Byteenable = 0 leaves the register unchanged.

Reads
- avms_read_i sampled at edge N gives readdata plus readdatavalid = 1 at edge N+1, for exactly one cycle. Back-to-back reads are supported at one per cycle.
- Simultaneous read and write to the same address returns the old value.
- readdata holds its last value when readdatavalid = 0.

Decode
- Standard hex table, ACTIVE_LOW values given: 0=0x40, 1=0x79, 8=0x00, A=0x08, F=0x0E.
- ACTIVE_LOW = 0 inverts all patterns.

Blink
- Prescaler counts 0..CLK_FREQ_HZ/(2*BLINK_HZ)-1. On wrap it returns to 0 and toggles the phase.
- Writing BLINK does not reset the prescaler.

PWM
- PWM_BITS-bit counter, free-running, wraps.
- Lit when BRIGHT = 2^PWM_BITS-1 (full on) or counter < BRIGHT.
- BRIGHT = 0 gives constant off.

Digit i output priority
- BLANK[i], or (BLINK[i] & phase), or PWM off -> off.
- Else RAW_EN[i] -> RAW pattern.
- Else decoded DIGITS.

Output timing
- segment_symbol_o is registered.
- A write at edge N is visible on the pins at edge N+1.
- Asynchronous reset mid-operation blanks the outputs immediately and drops any pending readdatavalid.

Test Plan:
- Reset, then release -> segments all 0x7F. One cycle later every digit shows 0x40. Read BRIGHT -> 0xF.
- Write DIGITS=0x00FEDCBA, byteenable=4'b0001 -> only digits 0,1 change: digit0=0x08, digit1 = B pattern 0x03, others 0x40. Read DIGITS back -> 0x000000BA with readdatavalid one cycle after the read.
- Write RAW_LO=0x0000007F, RAW_EN=0x1 -> digit0 = 0x7F. Clear RAW_EN -> digit0 returns to decoded value on the next edge.
- CLK_FREQ_HZ=8, BLINK_HZ=1, BLINK=0x2 -> digit1 alternates on/off every 4 cycles. STATUS bit0 toggles in step with it. Digit0 stays steady.
- PWM_BITS=4: BRIGHT=4 -> each digit lit for 4 of every 16 cycles. BRIGHT=0 -> always 0x7F. BRIGHT=15 -> always lit.
- Write STATUS, and assert rst_n low during an outstanding read -> STATUS unchanged, readdatavalid deasserts at once, outputs blank.

Source files
------------

// File: rtl/avalon_seg_display_ctrl.sv
// Avalon-MM seven-segment display controller for DE1-SoC HEX digits.
// Per-digit hex/raw/blank/blink control with global PWM dimming.
module avalon_seg_display_ctrl #(
  parameter int NUM_SEGMENT = 6,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BLINK_HZ    = 2,
  parameter int PWM_BITS    = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               avms_address_i,
  input  logic [3:0]               avms_byteenable_i,
  input  logic                     avms_write_i,
  input  logic [31:0]              avms_writedata_i,
  input  logic                     avms_read_i,
  output logic [31:0]              avms_readdata_o,
  output logic                     avms_readdatavalid_o,
  output logic [NUM_SEGMENT*7-1:0] segment_symbol_o
);

  localparam int PRESC_MAX = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int PW = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_MAX - 1);
  localparam logic [7:0] DIG_MASK =
    8'((9'd1 << NUM_SEGMENT) - 9'd1);
  localparam logic [31:0] NIB_MASK =
    32'((64'd1 << (4 * NUM_SEGMENT)) - 64'd1);
  localparam logic [6:0] SEG_OFF =
    (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

  // Control state is kept 8 digits wide; lanes above
  // NUM_SEGMENT are never written and stay at zero.
  logic [31:0]         digits_q, digits_d;
  logic [7:0]          raw_en_q, raw_en_d;
  logic [7:0]          blank_q, blank_d;
  logic [7:0]          blink_q, blink_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [7:0][6:0]     raw_q, raw_d;

  logic [PW-1:0]       presc_q, presc_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic [NUM_SEGMENT*7-1:0] seg_q, seg_d;

  logic [31:0]         rd_view;
  logic [31:0]         wr_merged;
  logic                pwm_lit;
  logic [7:0]          dig_off;

  function automatic logic [6:0] hex_seg(
    input logic [3:0] h
  );
    logic [6:0] p;
    case (h)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return (ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  always_comb begin
    rd_view = '0;
    unique case (avms_address_i)
      3'd0: rd_view = digits_q;
      3'd1: rd_view = {24'd0, raw_en_q};
      3'd2: rd_view = {24'd0, blank_q};
      3'd3: rd_view = {24'd0, blink_q};
      3'd4: rd_view = 32'(bright_q);
      3'd5: rd_view = {1'b0, raw_q[3], 1'b0, raw_q[2],
                       1'b0, raw_q[1], 1'b0, raw_q[0]};
      3'd6: rd_view = {1'b0, raw_q[7], 1'b0, raw_q[6],
                       1'b0, raw_q[5], 1'b0, raw_q[4]};
      3'd7: rd_view = {16'd0, 8'(NUM_SEGMENT),
                       7'd0, phase_q};
    endcase
  end

  // Disabled byte lanes keep the current register contents.
  always_comb begin
    wr_merged = '0;
    for (int b = 0; b < 4; b++) begin
      wr_merged[8*b +: 8] = avms_byteenable_i[b]
        ? avms_writedata_i[8*b +: 8]
        : rd_view[8*b +: 8];
    end
  end

  always_comb begin
    digits_d = digits_q;
    raw_en_d = raw_en_q;
    blank_d  = blank_q;
    blink_d  = blink_q;
    bright_d = bright_q;
    raw_d    = raw_q;
    if (avms_write_i) begin
      unique case (avms_address_i)
        3'd0: digits_d = wr_merged & NIB_MASK;
        3'd1: raw_en_d = wr_merged[7:0] & DIG_MASK;
        3'd2: blank_d  = wr_merged[7:0] & DIG_MASK;
        3'd3: blink_d  = wr_merged[7:0] & DIG_MASK;
        3'd4: bright_d = wr_merged[PWM_BITS-1:0];
        3'd5: begin
          for (int i = 0; i < 4; i++) begin
            raw_d[i] = DIG_MASK[i]
              ? wr_merged[8*i +: 7] : 7'd0;
          end
        end
        3'd6: begin
          for (int i = 0; i < 4; i++) begin
            raw_d[i+4] = DIG_MASK[i+4]
              ? wr_merged[8*i +: 7] : 7'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    phase_d = phase_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
    pwm_d = pwm_q + PWM_BITS'(1);
  end

  always_comb begin
    rvalid_d = avms_read_i;
    rdata_d  = avms_read_i ? rd_view : rdata_q;
  end

  always_comb begin
    pwm_lit = (bright_q == BRIGHT_MAX) || (pwm_q < bright_q);
    dig_off = blank_q | (blink_q & {8{phase_q}})
            | {8{~pwm_lit}};
    seg_d = '0;
    for (int i = 0; i < NUM_SEGMENT; i++) begin
      unique case (1'b1)
        dig_off[i]:
          seg_d[7*i +: 7] = SEG_OFF;
        (!dig_off[i] && raw_en_q[i]):
          seg_d[7*i +: 7] = raw_q[i];
        default:
          seg_d[7*i +: 7] = hex_seg(digits_q[4*i +: 4]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      raw_en_q <= '0;
      blank_q  <= '0;
      blink_q  <= '0;
      bright_q <= BRIGHT_MAX;
      raw_q    <= '0;
      presc_q  <= '0;
      phase_q  <= 1'b0;
      pwm_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      seg_q    <= {NUM_SEGMENT{SEG_OFF}};
    end else begin
      digits_q <= digits_d;
      raw_en_q <= raw_en_d;
      blank_q  <= blank_d;
      blink_q  <= blink_d;
      bright_q <= bright_d;
      raw_q    <= raw_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      pwm_q    <= pwm_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      seg_q    <= seg_d;
    end
  end

  assign avms_readdata_o      = rdata_q;
  assign avms_readdatavalid_o = rvalid_q;
  assign segment_symbol_o     = seg_q;

endmodule

// File: tb/tb_avalon_seg_display_ctrl.sv
// Bench for avalon_seg_display_ctrl: random register traffic
// checked against a cycle-count based behavioural model.
module tb_avalon_seg_display_ctrl;

  localparam int NS = 6;
  localparam logic [41:0] ALL_OFF = {NS{7'h7F}};
  localparam logic [6:0] HEX_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [31:0] IMPL [8] = '{
    32'h00FF_FFFF, 32'h3F, 32'h3F, 32'h3F,
    32'h0F, 32'h7F7F_7F7F, 32'h0000_7F7F, 32'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = '0;
  logic [3:0]  byteen = '0;
  logic        write = 1'b0;
  logic [31:0] wdata = '0;
  logic        read = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [41:0] seg;

  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  logic [31:0] m_reg [8];

  avalon_seg_display_ctrl #(
    .NUM_SEGMENT(NS), .CLK_FREQ_HZ(8), .BLINK_HZ(1),
    .PWM_BITS(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avms_address_i(addr),
    .avms_byteenable_i(byteen),
    .avms_write_i(write),
    .avms_writedata_i(wdata),
    .avms_read_i(read),
    .avms_readdata_o(rdata),
    .avms_readdatavalid_o(rvalid),
    .segment_symbol_o(seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_reg[4] = 32'd15;
  endfunction

  function automatic void m_write(
    input logic [2:0] a, input logic [3:0] be,
    input logic [31:0] d);
    if (a == 3'd7) return;
    for (int b = 0; b < 4; b++)
      if (be[b]) m_reg[a][8*b +: 8] = d[8*b +: 8];
    m_reg[a] = m_reg[a] & IMPL[a];
  endfunction

  // m = clock edges elapsed before the one being observed
  function automatic logic phase_at(input int m);
    return ((m / 4) % 2) == 1;
  endfunction

  function automatic logic [31:0] m_read(
    input logic [2:0] a, input int m);
    if (a == 3'd7)
      return {16'd0, 8'd6, 7'd0, phase_at(m)};
    return m_reg[a];
  endfunction

  function automatic logic [41:0] exp_seg(input int m);
    logic [41:0] v;
    int br;
    logic lit, off;
    logic [6:0] raw;
    v = '0;
    br = int'(m_reg[4][3:0]);
    lit = (br == 15) || ((m % 16) < br);
    for (int i = 0; i < NS; i++) begin
      if (i < 4) raw = m_reg[5][8*i +: 7];
      else raw = m_reg[6][8*(i-4) +: 7];
      off = m_reg[2][i] || (m_reg[3][i] && phase_at(m))
         || !lit;
      if (off) v[7*i +: 7] = 7'h7F;
      else if (m_reg[1][i]) v[7*i +: 7] = raw;
      else v[7*i +: 7] = HEX_AL[m_reg[0][4*i +: 4]];
    end
    return v;
  endfunction

  task automatic bus_write(
    input logic [2:0] a, input logic [3:0] be,
    input logic [31:0] d);
    addr = a; byteen = be; wdata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0; byteen = '0;
    m_write(a, be, d);
    @(negedge clk);
  endtask

  task automatic bus_read(
    input logic [2:0] a, output logic [31:0] d,
    output logic v);
    addr = a; read = 1'b1;
    @(negedge clk);
    d = rdata; v = rvalid;
    read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    m_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (seg !== ALL_OFF || rvalid !== 1'b0
        || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state seg=%h rv=%b rd=%h exp %h 0 0",
               seg, rvalid, rdata, ALL_OFF);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (seg !== ALL_OFF) begin
      n_fail++;
      $display("FAIL release_off got %h exp %h", seg, ALL_OFF);
    end
    @(negedge clk);
    n_checks++;
    if (seg !== {NS{7'h40}} || seg !== exp_seg(cyc - 1)) begin
      n_fail++;
      $display("FAIL first_digits got %h exp %h",
               seg, {NS{7'h40}});
    end
    bus_read(3'd4, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'hF) begin
      n_fail++;
      $display("FAIL bright_reset got v=%b %h exp 1 f", v, d);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic v;
    logic [41:0] e;
    bus_write(3'd0, 4'b0001, 32'h00FE_DCBA);
    e = {{4{7'h40}}, 7'h03, 7'h08};
    n_checks++;
    if (seg !== e || seg !== exp_seg(cyc - 1)) begin
      n_fail++;
      $display("FAIL byte_lane_seg got %h exp %h", seg, e);
    end
    bus_read(3'd0, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0000_00BA) begin
      n_fail++;
      $display("FAIL digits_read got v=%b %h exp 1 ba", v, d);
    end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0000_00BA) begin
      n_fail++;
      $display("FAIL read_hold got v=%b %h exp 0 ba",
               rvalid, rdata);
    end
    bus_write(3'd0, 4'b0000, 32'hFFFF_FFFF);
    bus_read(3'd0, d, v);
    n_checks++;
    if (d !== 32'h0000_00BA) begin
      n_fail++;
      $display("FAIL be_zero got %h exp ba", d);
    end
  endtask

  task automatic test_raw();
    logic [41:0] e;
    bus_write(3'd5, 4'hF, 32'h0000_007F);
    bus_write(3'd1, 4'hF, 32'h1);
    e = {{4{7'h40}}, 7'h03, 7'h7F};
    n_checks++;
    if (seg !== e || seg !== exp_seg(cyc - 1)) begin
      n_fail++;
      $display("FAIL raw_on got %h exp %h", seg, e);
    end
    bus_write(3'd5, 4'b0010, 32'h0000_1200);
    bus_write(3'd1, 4'hF, 32'h2);
    e = {{4{7'h40}}, 7'h12, 7'h08};
    n_checks++;
    if (seg !== e || seg !== exp_seg(cyc - 1)) begin
      n_fail++;
      $display("FAIL raw_switch got %h exp %h", seg, e);
    end
    bus_write(3'd1, 4'hF, 32'h0);
    e = {{4{7'h40}}, 7'h03, 7'h08};
    n_checks++;
    if (seg !== e) begin
      n_fail++;
      $display("FAIL raw_off got %h exp %h", seg, e);
    end
  endtask

  task automatic test_blink();
    int toggles;
    logic prev;
    bus_write(3'd4, 4'h1, 32'hF);
    bus_write(3'd2, 4'hF, 32'h0);
    bus_write(3'd3, 4'hF, 32'h2);
    toggles = 0;
    prev = seg[13:7] == 7'h7F;
    addr = 3'd7; read = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b1
          || rdata !== m_read(3'd7, cyc - 1)) begin
        n_fail++;
        $display("FAIL status_stream got v=%b %h exp 1 %h",
                 rvalid, rdata, m_read(3'd7, cyc - 1));
      end
      n_checks++;
      if (seg !== exp_seg(cyc - 1)) begin
        n_fail++;
        $display("FAIL blink_seg got %h exp %h",
                 seg, exp_seg(cyc - 1));
      end
      if ((seg[13:7] == 7'h7F) != prev) toggles++;
      prev = seg[13:7] == 7'h7F;
    end
    read = 1'b0;
    n_checks++;
    if (toggles < 3 || toggles > 4) begin
      n_fail++;
      $display("FAIL blink_toggles got %0d exp 3..4", toggles);
    end
    bus_write(3'd3, 4'hF, 32'h0);
  endtask

  task automatic test_pwm();
    int lit;
    bus_write(3'd4, 4'h1, 32'h4);
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (seg !== exp_seg(cyc - 1)) begin
        n_fail++;
        $display("FAIL pwm4_seg got %h exp %h",
                 seg, exp_seg(cyc - 1));
      end
      if (seg[6:0] != 7'h7F) lit++;
    end
    n_checks++;
    if (lit != 4) begin
      n_fail++;
      $display("FAIL pwm4_duty got %0d exp 4", lit);
    end
    bus_write(3'd4, 4'h1, 32'h0);
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (seg !== ALL_OFF) lit++;
    end
    n_checks++;
    if (lit != 0) begin
      n_fail++;
      $display("FAIL pwm0_lit got %0d exp 0", lit);
    end
    bus_write(3'd4, 4'h1, 32'hF);
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (seg[6:0] != 7'h7F) lit++;
    end
    n_checks++;
    if (lit != 16) begin
      n_fail++;
      $display("FAIL pwm15_lit got %0d exp 16", lit);
    end
  endtask

  task automatic test_random();
    logic [2:0] a;
    logic [31:0] d;
    logic v;
    for (int it = 0; it < 48; it++) begin
      a = 3'($urandom_range(0, 7));
      bus_write(a, 4'($urandom_range(0, 15)), $urandom);
      n_checks++;
      if (seg !== exp_seg(cyc - 1)) begin
        n_fail++;
        $display("FAIL rand_seg it=%0d got %h exp %h",
                 it, seg, exp_seg(cyc - 1));
      end
      a = 3'($urandom_range(0, 7));
      bus_read(a, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== m_read(a, cyc - 1)) begin
        n_fail++;
        $display("FAIL rand_read a=%0d got v=%b %h exp 1 %h",
                 a, v, d, m_read(a, cyc - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old, nw;
    read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr = 3'(k);
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b1
          || rdata !== m_read(3'(k), cyc - 1)) begin
        n_fail++;
        $display("FAIL b2b_read a=%0d got v=%b %h exp 1 %h",
                 k, rvalid, rdata, m_read(3'(k), cyc - 1));
      end
    end
    old = m_reg[2];
    nw = $urandom;
    addr = 3'd2; byteen = 4'hF; wdata = nw; write = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0; byteen = '0;
    m_write(3'd2, 4'hF, nw);
    n_checks++;
    if (rdata !== old) begin
      n_fail++;
      $display("FAIL rw_same got %h exp %h", rdata, old);
    end
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0 || seg !== exp_seg(cyc - 1)) begin
      n_fail++;
      $display("FAIL rw_after got v=%b seg=%h exp 0 %h",
               rvalid, seg, exp_seg(cyc - 1));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    bus_write(3'd0, 4'hF, 32'h0012_3456);
    bus_write(3'd7, 4'hF, 32'hFFFF_FFFF);
    addr = 3'd7; read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_read got %b exp 1", rvalid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || seg !== ALL_OFF) begin
      n_fail++;
      $display("FAIL async_reset got v=%b seg=%h exp 0 %h",
               rvalid, seg, ALL_OFF);
    end
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (seg !== exp_seg(cyc - 1)) begin
      n_fail++;
      $display("FAIL post_reset_seg got %h exp %h",
               seg, exp_seg(cyc - 1));
    end
    bus_read(3'd7, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== m_read(3'd7, cyc - 1)) begin
      n_fail++;
      $display("FAIL status_ro got %h exp %h",
               d, m_read(3'd7, cyc - 1));
    end
    bus_read(3'd0, d, v);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL digits_cleared got %h exp 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_raw();
    test_blink();
    test_pwm();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
